// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for shift_add_multiplier (start/busy/done).
// The master drives operands and start; the slave returns busy, done and the product.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned add-and-shift multiplier, one partial product per clock.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_multiplier_if.slave bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     mcand_reg, mcand_next;
    logic [WIDTH-1:0]  mplr_reg, mplr_next;
    logic [PW-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [PW-1:0]     product_reg, product_next;
    logic              busy_reg, done_reg;

    logic [PW-1:0]     addend;
    logic [PW-1:0]     sum;
    logic [PW-1:0]     carry;
    logic              last_iter;

    assign addend   = mplr_reg[0] ? mcand_reg : '0;
    assign carry[0] = 1'b0;

    // Ripple adder; the carry out of the top bit is always zero and is not formed.
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_ripple
            assign sum[gi] = acc_reg[gi] ^ addend[gi] ^ carry[gi];
            if (gi < PW - 1) begin : g_carry
                assign carry[gi+1] = (acc_reg[gi] & addend[gi]) |
                                     (acc_reg[gi] & carry[gi])  |
                                     (addend[gi]  & carry[gi]);
            end
        end
    endgenerate

`ifdef EARLY_TERM_EN
    assign last_iter = (cnt_reg == CNT_LAST) || ((mplr_reg >> 1) == '0);
`else
    assign last_iter = (cnt_reg == CNT_LAST);
`endif

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplr_next    = mplr_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mcand_next = {{WIDTH{1'b0}}, bus.a};
                    mplr_next  = bus.b;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                acc_next   = sum;
                mcand_next = mcand_reg << 1;
                mplr_next  = mplr_reg >> 1;
                cnt_next   = cnt_reg + 1'b1;
                if (last_iter) begin
                    product_next = sum;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done are flopped from the next state so they leave straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplr_reg    <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplr_reg    <= mplr_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            busy_reg    <= (state_next == BUSY);
            done_reg    <= (state_next == DONE);
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus random operands
// compared against plain a*b and an iteration-count model.
module tb_shift_add_multiplier;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    shift_add_multiplier_if #(.WIDTH(W)) bus ();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected number of busy cycles for a given multiplier.
    function automatic int iters(input logic [W-1:0] y);
        int n;
`ifdef EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++) if (y[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input bit inject, input string tag);
        int n;
        logic [2*W-1:0] exp;
        exp = (2*W)'(x) * (2*W)'(y);
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 1) begin
                bus.start = 1'b1; bus.a = W'(2); bus.b = W'(2);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check({tag, "/busy_cycles"}, 32'(n), 32'(iters(y)));
        check({tag, "/done"}, 32'(bus.done), 32'd1);
        check({tag, "/product"}, 32'(bus.product), 32'(exp));
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "/product_hold"}, 32'(bus.product), 32'(exp));
        $display("op %s: a=%0d b=%0d product=%0h cycles=%0d", tag, x, y, bus.product, n);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;

        // Reset state
        #2;
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/product", 32'(bus.product), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        op(W'(3), W'(5), 1'b0, "t1_3x5");
        op(W'(15), W'(15), 1'b0, "t2_15x15");
        op(W'(9), W'(15), 1'b0, "t2_9x15");
        op(W'(7), W'(0), 1'b0, "t3_7x0");
        op(W'(5), W'(1), 1'b0, "t3_5x1");
        op(W'(3), W'(5), 1'b1, "t4_ignore_start");
        @(posedge clk); #1;
        check("t4/product_idle", 32'(bus.product), 32'h0F);

        // Asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.a = W'(15); bus.b = W'(15);
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1; #1;
        check("t5/busy", 32'(bus.busy), 32'd0);
        check("t5/done", 32'(bus.done), 32'd0);
        check("t5/product", 32'(bus.product), 32'd0);
        $display("op t5_reset: busy=%0d done=%0d product=%0h", bus.busy, bus.done, bus.product);
        @(negedge clk); rst = 1'b0;
        op(W'(6), W'(7), 1'b0, "t5_6x7");

        // Back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1; bus.a = W'(2); bus.b = W'(3);
        @(posedge clk); #1;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
        check("t6/done1", 32'(bus.done), 32'd1);
        check("t6/product1", 32'(bus.product), 32'h06);
        bus.a = W'(4); bus.b = W'(5);
        @(posedge clk); #1;
        check("t6/idle_busy", 32'(bus.busy), 32'd0);
        check("t6/idle_done", 32'(bus.done), 32'd0);
        check("t6/idle_product", 32'(bus.product), 32'h06);
        @(posedge clk); #1;
        check("t6/accept_busy", 32'(bus.busy), 32'd1);
        check("t6/busy_product", 32'(bus.product), 32'h06);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
        check("t6/done2", 32'(bus.done), 32'd1);
        check("t6/product2", 32'(bus.product), 32'h14);
        $display("op t6_back_to_back: product=%0h", bus.product);
        @(posedge clk); #1;

        // Random operands
        for (int i = 0; i < 24; i++) begin
            op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
